// File: rtl/wb_scoreboard_arbiter.sv
// Write-back front end: per-register busy scoreboard, hazard detection, and
// round-robin arbitration of ALU/LSU results onto the single register file write port.
module wb_scoreboard_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,

    input  logic [AW-1:0]   rs1_address,
    input  logic [AW-1:0]   rs2_address,
    output logic            hazard,

    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,

    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,

    output logic            wb_write_enable,
    output logic [AW-1:0]   wb_rd_address,
    output logic [XLEN-1:0] wb_write_data,
    output logic            wb_error
);

    localparam int NREG = 1 << AW;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    src_e            last_grant;

    logic            alu_grant;
    logic            lsu_grant;
    logic            any_grant;
    logic [AW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    logic            issue_fire;
    logic            grant_error;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        issue_ready = !busy[issue_rd] || (wb_write_enable && wb_rd_address == issue_rd);
        hazard      = busy[rs1_address] | busy[rs2_address];
        issue_fire  = issue_valid && issue_ready;

        // Reset drops the grant so no result is consumed while the write is suppressed.
        alu_grant   = !reset && alu_valid && (!lsu_valid || last_grant == SRC_LSU);
        lsu_grant   = !reset && lsu_valid && (!alu_valid || last_grant == SRC_ALU);
        any_grant   = alu_grant || lsu_grant;
        grant_rd    = lsu_grant ? lsu_rd   : alu_rd;
        grant_data  = lsu_grant ? lsu_data : alu_data;
        alu_ready   = alu_grant;
        lsu_ready   = lsu_grant;

        grant_error = any_grant && (grant_rd != '0) && !busy[grant_rd]
                      && !(issue_fire && issue_rd == grant_rd);

        // Clear for the retiring write first, then the issue set, so set wins.
        busy_next = busy;
        if (wb_write_enable) begin
            busy_next[wb_rd_address] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy            <= '0;
            last_grant      <= SRC_LSU;
            wb_write_enable <= 1'b0;
            wb_rd_address   <= '0;
            wb_write_data   <= '0;
            wb_error        <= 1'b0;
        end else begin
            busy            <= busy_next;
            wb_write_enable <= any_grant && (grant_rd != '0);
            if (any_grant) begin
                last_grant <= lsu_grant ? SRC_LSU : SRC_ALU;
            end
            // Address/data only move when a real write goes out; otherwise they hold.
            if (any_grant && grant_rd != '0) begin
                wb_rd_address <= grant_rd;
                wb_write_data <= grant_data;
            end
            if (grant_error) begin
                wb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Directed plus randomized bench for wb_scoreboard_arbiter against a per-cycle
// behavioural model of the scoreboard, arbiter and write port.
module tb_wb_scoreboard_arbiter;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic [AW-1:0]   rs1_address;
    logic [AW-1:0]   rs2_address;
    logic            hazard;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            wb_write_enable;
    logic [AW-1:0]   wb_rd_address;
    logic [XLEN-1:0] wb_write_data;
    logic            wb_error;

    wb_scoreboard_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_ready     (issue_ready),
        .rs1_address     (rs1_address),
        .rs2_address     (rs2_address),
        .hazard          (hazard),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .lsu_valid       (lsu_valid),
        .lsu_rd          (lsu_rd),
        .lsu_data        (lsu_data),
        .lsu_ready       (lsu_ready),
        .wb_write_enable (wb_write_enable),
        .wb_rd_address   (wb_rd_address),
        .wb_write_data   (wb_write_data),
        .wb_error        (wb_error)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed    = 0;

    // Reference model: set of pending registers plus the write expected next cycle.
    bit [31:0]       mb         = '0;
    bit              m_we       = 1'b0;
    bit [AW-1:0]     m_addr     = '0;
    bit [XLEN-1:0]   m_data     = '0;
    bit              m_err      = 1'b0;
    bit              m_last_lsu = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
    endtask

    // Called at a falling edge with inputs applied; checks one cycle, advances to the next falling edge.
    task automatic tick(output bit ga, output bit gl);
        bit            exp_ir;
        bit            acc;
        bit            g;
        bit [AW-1:0]   grd;
        bit [XLEN-1:0] gdat;
        #1;
        exp_ir = !mb[issue_rd] || (m_we && m_addr == issue_rd);
        ga = !reset && alu_valid && (!lsu_valid || m_last_lsu);
        gl = !reset && lsu_valid && (!alu_valid || !m_last_lsu);
        check("issue_ready", issue_ready, exp_ir);
        check("hazard", hazard, mb[rs1_address] || mb[rs2_address]);
        check("alu_ready", alu_ready, ga);
        check("lsu_ready", lsu_ready, gl);
        check("wb_write_enable", wb_write_enable, m_we);
        check("wb_error", wb_error, m_err);
        if (m_we) begin
            check("wb_rd_address", wb_rd_address, m_addr);
            check("wb_write_data", wb_write_data, m_data);
        end
        if (reset) begin
            mb = '0; m_we = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0; m_last_lsu = 1'b1;
        end else begin
            acc  = issue_valid && exp_ir;
            g    = ga || gl;
            grd  = gl ? lsu_rd : alu_rd;
            gdat = gl ? lsu_data : alu_data;
            if (g && grd != 0 && !mb[grd] && !(acc && issue_rd == grd)) m_err = 1'b1;
            if (m_we) mb[m_addr] = 1'b0;
            if (acc && issue_rd != 0) mb[issue_rd] = 1'b1;
            m_we = g && grd != 0;
            if (m_we) begin
                m_addr = grd;
                m_data = gdat;
            end
            if (g) m_last_lsu = gl;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit ga, gl;
        bit order [4];
        int ai, li, n;
        reset = 1'b1; issue_valid = 0; issue_rd = 0; rs1_address = 0; rs2_address = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        @(posedge clk);
        @(negedge clk);
        tick(ga, gl);
        check("rst_addr", wb_rd_address, 0);
        check("rst_data", wb_write_data, 0);
        check("rst_we", wb_write_enable, 0);
        reset = 1'b0;

        // Basic issue -> ALU result -> write
        issue_valid = 1; issue_rd = 5; tick(ga, gl);
        issue_valid = 0; tick(ga, gl);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; rs1_address = 5;
        #1; check("t1_alu_ready", alu_ready, 1); check("t1_hazard", hazard, 1);
        tick(ga, gl);
        alu_valid = 0;
        #1; check("t1_we", wb_write_enable, 1); check("t1_addr", wb_rd_address, 5);
        check("t1_data", wb_write_data, 32'hDEADBEEF);
        tick(ga, gl);
        #1; check("t1_busy_cleared", hazard, 0);
        tick(ga, gl);

        // WAW blocking and issue in the retire cycle
        rs1_address = 7; issue_valid = 1; issue_rd = 7; tick(ga, gl);
        #1; check("t2_waw_block", issue_ready, 0); check("t2_hazard", hazard, 1);
        tick(ga, gl);
        issue_valid = 0; alu_valid = 1; alu_rd = 7; alu_data = 32'h77; tick(ga, gl);
        alu_valid = 0; issue_valid = 1; issue_rd = 7;
        #1; check("t2_retire_we", wb_write_enable, 1); check("t2_retire_ready", issue_ready, 1);
        tick(ga, gl);
        issue_valid = 0;
        #1; check("t2_set_wins", hazard, 1);
        tick(ga, gl);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78; tick(ga, gl);
        alu_valid = 0; tick(ga, gl);
        #1; check("t2_drained", hazard, 0);
        tick(ga, gl);

        // Round robin after reset: ALU wins the first tie
        reset = 1; tick(ga, gl); reset = 0;
        for (int r = 1; r <= 4; r++) begin
            issue_valid = 1; issue_rd = AW'(r); tick(ga, gl);
        end
        issue_valid = 0;
        ai = 0; li = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'hA1;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB2;
        for (int c = 0; c < 4; c++) begin
            #1; order[c] = alu_ready;
            check("t3_one_grant", alu_ready + lsu_ready, 1);
            tick(ga, gl);
            if (ga) begin
                ai++;
                if (ai == 2) alu_valid = 0; else begin alu_rd = 3; alu_data = 32'hA3; end
            end
            if (gl) begin
                li++;
                if (li == 2) lsu_valid = 0; else begin lsu_rd = 4; lsu_data = 32'hB4; end
            end
        end
        check("t3_order0", order[0], 1);
        check("t3_order1", order[1], 0);
        check("t3_order2", order[2], 1);
        check("t3_order3", order[3], 0);
        tick(ga, gl);
        rs1_address = 1; rs2_address = 4;
        #1; check("t3_no_lost", hazard, 0);
        tick(ga, gl);

        // x0 destination
        rs1_address = 0; rs2_address = 0;
        issue_valid = 1; issue_rd = 0; tick(ga, gl);
        issue_valid = 0; alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        #1; check("t4_alu_ready", alu_ready, 1); check("t4_hazard_x0", hazard, 0);
        tick(ga, gl);
        alu_valid = 0;
        #1; check("t4_no_write", wb_write_enable, 0);
        tick(ga, gl);

        // Result for a non-busy register
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99; tick(ga, gl);
        lsu_valid = 0;
        #1; check("t5_we", wb_write_enable, 1); check("t5_err", wb_error, 1);
        for (int c = 0; c < 3; c++) tick(ga, gl);
        check("t5_err_sticky", wb_error, 1);

        // Reset in the grant cycle
        issue_valid = 1; issue_rd = 3; tick(ga, gl);
        issue_valid = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'h33; reset = 1;
        tick(ga, gl);
        reset = 0; alu_valid = 0; rs1_address = 3;
        #1; check("t6_no_write", wb_write_enable, 0); check("t6_err", wb_error, 0);
        check("t6_busy", hazard, 0);
        tick(ga, gl);

        // Randomized traffic checked cycle by cycle against the model
        n = 3000;
        for (int c = 0; c < n; c++) begin
            if (!alu_valid && $urandom_range(2) == 0) begin
                alu_valid = 1; alu_rd = AW'($urandom_range(7)); alu_data = $urandom;
            end
            if (!lsu_valid && $urandom_range(2) == 0) begin
                lsu_valid = 1; lsu_rd = AW'($urandom_range(7)); lsu_data = $urandom;
            end
            issue_valid = 1'($urandom_range(1));
            issue_rd    = AW'($urandom_range(7));
            rs1_address = AW'($urandom_range(7));
            rs2_address = AW'($urandom_range(7));
            reset       = ($urandom_range(199) == 0);
            tick(ga, gl);
            if (ga || reset) alu_valid = 0;
            if (gl || reset) lsu_valid = 0;
        end
        reset = 0;
        idle();
        tick(ga, gl);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
